// File: rtl/pulse_receiver.sv
// Stretched-pulse line receiver: synchronizes line_in, measures each high run and
// strobes pulse_out (accepted width) or err (too short / too long). Optional macro: PULSE_RX_COUNT_EN.
module pulse_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LEN     = 6,
  parameter int MAX_LEN     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  output logic       pulse_out,
  output logic       err,
  output logic       busy
`ifdef PULSE_RX_COUNT_EN
  ,
  output logic [7:0] event_count
`endif
);

  localparam logic [7:0] MIN_L = 8'(MIN_LEN);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HIGH, WAIT_LOW} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             len, len_nxt;
  logic                   pulse_nxt, err_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   line_s;

  // Chain resets to 1 so a line already high at release looks like a pulse in progress.
  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], line_in};
  end

  assign line_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOW;
      len       <= '0;
      pulse_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      pulse_out <= pulse_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    pulse_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (line_s) begin
          state_nxt = HIGH;
          len_nxt   = 8'd1;
        end
      end
      HIGH: begin
        if (!line_s) begin
          state_nxt = IDLE;
          if (len >= MIN_L && len <= MAX_L) pulse_nxt = 1'b1;
          else                              err_nxt   = 1'b1;
        end else if (len == MAX_L) begin
          // Too long: report once, then ignore the rest of this run.
          state_nxt = WAIT_LOW;
          err_nxt   = 1'b1;
        end else begin
          len_nxt = len + 8'd1;
        end
      end
      WAIT_LOW: begin
        if (!line_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef PULSE_RX_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)            event_count <= '0;
    else if (pulse_out) event_count <= event_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pulse_receiver.sv
// Randomized + directed bench: the whole line/reset waveform is built first, a
// run-length reference model derives expected strobes, and a monitor scoreboards them.
module tb_pulse_receiver;
  localparam int SYNC = 2;
  localparam int MINL = 6;
  localparam int MAXL = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_in = 1'b0;
  logic pulse_out, err, busy;
`ifdef PULSE_RX_COUNT_EN
  logic [7:0] event_count;
`endif

  pulse_receiver #(.SYNC_STAGES(SYNC), .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .line_in(line_in),
    .pulse_out(pulse_out), .err(err), .busy(busy)
`ifdef PULSE_RX_COUNT_EN
    , .event_count(event_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int t; bit is_err;} ev_t;

  bit  lq[$], rq[$];
  ev_t exp_q[$];
  bit  vis[], poison[], ep[];
  int  n;
  int  checks = 0, failures = 0;

  task automatic seg(input bit lvl, input int cnt, input bit r);
    repeat (cnt) begin lq.push_back(lvl); rq.push_back(r); end
  endtask

  task automatic chk(input bit ok, input string name, input int t, input int act, input int want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", name, t, act, want);
    end
  endtask

  // Reference model: line level as seen by the decision logic at each edge, with
  // reset cycles (and the sync refill after them) marked as poisoned high.
  task automatic build_model();
    int last_rst = -1000;
    n = lq.size();
    vis = new[n]; poison = new[n]; ep = new[n];
    for (int t = 0; t < n; t++) begin
      ep[t] = 1'b0;
      if (rq[t]) begin
        last_rst = t; vis[t] = 1'b1; poison[t] = 1'b1;
      end else if (t - last_rst <= SYNC || t < SYNC) begin
        vis[t] = 1'b1; poison[t] = 1'b1;
      end else begin
        vis[t] = lq[t-SYNC]; poison[t] = 1'b0;
      end
    end
    for (int t = 0; t < n; ) begin
      int a, b, pf;
      if (!vis[t]) begin t++; continue; end
      a = t; b = t;
      while (b + 1 < n && vis[b+1]) b++;
      pf = n + 100;
      for (int k = b; k >= a; k--) if (poison[k]) pf = k;
      if (!poison[a]) begin
        if (b - a + 1 > MAXL) begin
          if (a + MAXL < pf) exp_q.push_back('{a + MAXL, 1'b1});
        end else if (pf > b && b + 1 < n) begin
          exp_q.push_back('{b + 1, (b - a + 1 < MINL)});
          if (b - a + 1 >= MINL) ep[b+1] = 1'b1;
        end
      end
      t = b + 1;
    end
  endtask

  initial begin
    // reset, then nominal / short / stuck-high pulses
    seg(0, 3, 1); seg(0, 5, 0);
    seg(1, 8, 0); seg(0, 6, 0);
    seg(1, 3, 0); seg(0, 6, 0);
    seg(1, 40, 0); seg(0, 6, 0);
    // width boundaries
    seg(1, MINL-1, 0); seg(0, 5, 0);
    seg(1, MINL, 0);   seg(0, 5, 0);
    seg(1, MAXL, 0);   seg(0, 5, 0);
    seg(1, MAXL+1, 0); seg(0, 5, 0);
    seg(1, 1, 0);      seg(0, 5, 0);
    // back-to-back with one and two low cycles
    seg(1, 8, 0); seg(0, 1, 0); seg(1, 8, 0); seg(0, 2, 0); seg(1, 8, 0); seg(0, 6, 0);
    // line high through reset release, low at cycle 5, then a good pulse
    seg(1, 3, 0); seg(1, 4, 1); seg(1, 5, 0); seg(0, 4, 0); seg(1, 8, 0); seg(0, 6, 0);
    // reset mid-pulse, line stays high; then reset mid-pulse, line drops during reset
    seg(1, 4, 0); seg(1, 2, 1); seg(1, 4, 0); seg(0, 6, 0);
    seg(1, 5, 0); seg(1, 1, 1); seg(0, 2, 1); seg(0, 6, 0);
    // random widths/gaps with occasional resets
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 12) == 0) seg(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1);
      seg(1, $urandom_range(1, 14), 0);
      seg(0, $urandom_range(1, 5), 0);
    end
    // enough good pulses to wrap an 8-bit event counter
    for (int i = 0; i < 258; i++) begin seg(1, 8, 0); seg(0, 2, 0); end
    seg(0, 20, 0);

    build_model();

    fork
      begin
        for (int t = 0; t < n; t++) begin
          line_in = lq[t]; rst = rq[t];
          @(posedge clk); #1;
        end
      end
      begin
        logic [7:0] exp_cnt = 8'd0;
        ev_t e;
        for (int t = 0; t < n; t++) begin
          @(negedge clk);
          chk(busy === vis[t], "busy", t, int'(busy), int'(vis[t]));
          chk(!(pulse_out === 1'b1 && err === 1'b1), "exclusive", t, int'({pulse_out, err}), 0);
          if (rq[t]) chk(pulse_out === 1'b0 && err === 1'b0, "reset_quiet", t, int'({pulse_out, err}), 0);
          while (exp_q.size() > 0 && exp_q[0].t < t) begin
            e = exp_q.pop_front();
            chk(1'b0, "missed_strobe", t, -1, e.t);
          end
          if (pulse_out !== 1'b0 || err !== 1'b0) begin
            if (exp_q.size() == 0) chk(1'b0, "extra_strobe", t, int'({pulse_out, err}), 0);
            else begin
              e = exp_q.pop_front();
              chk(e.t == t, "strobe_time", t, t, e.t);
              chk({pulse_out, err} === (e.is_err ? 2'b01 : 2'b10), "strobe_kind", t,
                  int'({pulse_out, err}), e.is_err ? 1 : 2);
            end
          end
`ifdef PULSE_RX_COUNT_EN
          if (rq[t])               exp_cnt = 8'd0;
          else if (t > 0 && ep[t-1]) exp_cnt = exp_cnt + 8'd1;
          chk(event_count === exp_cnt, "event_count", t, int'(event_count), int'(exp_cnt));
`endif
        end
      end
    join
    chk(exp_q.size() == 0, "queue_empty", n, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
